// File: rtl/sequence_1100_tx.sv
// sequence_1100_tx
//
// Moore-style serial frame transmitter feeding the overlapping "1100"
// sequence detector. A start request accepted in IDLE sends the 4-bit sync
// PATTERN (bit 3 first), then a DATA_W-bit payload MSB first, one bit per
// clock. A single DONE cycle with a done pulse follows, and then the line
// returns to IDLE.
//
// Parameters:
//   DATA_W   payload width in bits (>= 1)
//   PATTERN  sync pattern, sent bit 3 first
//   IDLE_LVL line level while not transmitting
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset; it takes priority over start
//   start  frame request, sampled only in IDLE and never queued
//   data   payload, captured on the edge that accepts start
//   x_out  serial line (registered)
//   busy   high while sync or payload bits are on the line (registered)
//   done   one-cycle pulse after the last payload bit (registered)
//
// All outputs are registered and are loaded with the value that belongs to
// the state being entered. This gives the line no combinational path from
// any input.

module sequence_1100_tx #(
    parameter int       DATA_W   = 8,
    parameter logic [3:0] PATTERN = 4'b1100,
    parameter logic     IDLE_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              x_out,
    output logic              busy,
    output logic              done
);

    // One counter serves both phases. It must be at least 2 bits wide so
    // that it can count the four sync bits, even for a narrow payload.
    localparam int CNT_W = (DATA_W > 4) ? $clog2(DATA_W) : 2;
    localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(3);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_shl;
    logic [1:0]        sync_nxt_idx;

    // Look-ahead values. x_out is registered, so each edge loads the bit
    // that the next cycle must carry, not the bit for the current cycle.
    always_comb begin
        shreg_shl    = shreg << 1;
        sync_nxt_idx = 2'd2 - cnt[1:0];   // PATTERN index for sync bit cnt+1
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            shreg <= '0;
            x_out <= IDLE_LVL;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt   <= '0;
                    x_out <= IDLE_LVL;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        shreg <= data;
                        state <= S_SYNC;
                        x_out <= PATTERN[3];
                        busy  <= 1'b1;
                    end
                end

                S_SYNC: begin
                    if (cnt == LAST_SYNC) begin
                        state <= S_DATA;
                        cnt   <= '0;
                        x_out <= shreg[DATA_W-1];
                    end else begin
                        cnt   <= cnt + 1'b1;
                        x_out <= PATTERN[sync_nxt_idx];
                    end
                end

                S_DATA: begin
                    shreg <= shreg_shl;
                    if (cnt == LAST_BIT) begin
                        state <= S_DONE;
                        cnt   <= '0;
                        x_out <= IDLE_LVL;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        x_out <= shreg_shl[DATA_W-1];
                    end
                end

                S_DONE: begin
                    // start is deliberately ignored here. The next frame can
                    // be accepted only after one full IDLE cycle.
                    state <= S_IDLE;
                    cnt   <= '0;
                    x_out <= IDLE_LVL;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    x_out <= IDLE_LVL;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_1100_tx.sv
// tb_sequence_1100_tx
//
// Bench for sequence_1100_tx. The stimulus process drives inputs on the
// falling edge. A reference model expands every accepted frame into the list
// of line states it must produce, and the expected output for each cycle is
// pushed to a scoreboard queue. A separate monitor pops one entry per cycle
// and compares it. The monitor also reassembles each frame from the line,
// checks it on every done pulse and runs a behavioural overlapping "1100"
// detector on the line.

module tb_sequence_1100_tx;

    localparam int         DATA_W   = 8;
    localparam logic [3:0] PATTERN  = 4'b1100;
    localparam logic       IDLE_LVL = 1'b0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              x_out, busy, done;

    always #5 clk = ~clk;

    sequence_1100_tx #(
        .DATA_W   (DATA_W),
        .PATTERN  (PATTERN),
        .IDLE_LVL (IDLE_LVL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .x_out (x_out),
        .busy  (busy),
        .done  (done)
    );

    typedef struct packed {
        logic x;
        logic b;
        logic d;
    } out_t;

    localparam out_t IDLE_OUT = '{x: IDLE_LVL, b: 1'b0, d: 1'b0};

    out_t              pend_q[$];   // model: line states still owed by the frame in flight
    out_t              exp_q[$];    // scoreboard: expected outputs, one per cycle
    logic [DATA_W-1:0] frame_q[$];  // payloads whose done pulse is still due

    int checks = 0;
    int errors = 0;

    // Monitor-side bookkeeping.
    int                cyc_n     = 0;
    int                done_cnt  = 0;
    int                last_done = 0;
    int                prev_done = 0;
    int                loop_ok   = 0;
    int                nbits     = 0;
    logic [DATA_W+3:0] rec       = '0;
    logic [3:0]        win       = '0;
    int                hits      = 0;
    int                hit_pos   = 0;

    // Apply one cycle of inputs and record what the outputs must be after
    // the next rising edge.
    task automatic step(input logic r, input logic s, input logic [DATA_W-1:0] d);
        out_t       e;
        out_t       t;
        logic [3:0] pat;
        @(negedge clk);
        rst   = r;
        start = s;
        data  = d;
        pat   = PATTERN;
        if (r) begin
            // The done entry is the second-to-last one owed. If it is still
            // pending, the reset aborts the frame and no done may appear.
            if (pend_q.size() >= 2)
                void'(frame_q.pop_back());
            pend_q.delete();
            e = IDLE_OUT;
        end else if (pend_q.size() > 0) begin
            e = pend_q.pop_front();
        end else if (s) begin
            for (int i = 3; i >= 0; i--) begin
                t = '{x: pat[i], b: 1'b1, d: 1'b0};
                pend_q.push_back(t);
            end
            for (int i = DATA_W - 1; i >= 0; i--) begin
                t = '{x: d[i], b: 1'b1, d: 1'b0};
                pend_q.push_back(t);
            end
            t = '{x: IDLE_LVL, b: 1'b0, d: 1'b1};
            pend_q.push_back(t);
            pend_q.push_back(IDLE_OUT);   // DONE state: line idle, start ignored
            frame_q.push_back(d);
            e = pend_q.pop_front();
        end else begin
            e = IDLE_OUT;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    // Monitor and scoreboard.
    initial begin
        out_t              e;
        logic [DATA_W-1:0] pay;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({x_out, busy, done} !== e) begin
                    errors++;
                    $display("FAIL line cyc=%0d got x=%b busy=%b done=%b exp x=%b busy=%b done=%b",
                             cyc_n, x_out, busy, done, e.x, e.b, e.d);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                prev_done = last_done;
                last_done = cyc_n;
                checks++;
                if (frame_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame cyc=%0d got unexpected done exp no frame pending", cyc_n);
                end else begin
                    pay = frame_q.pop_front();
                    if (nbits != DATA_W + 4 || rec !== {PATTERN, pay}) begin
                        errors++;
                        $display("FAIL frame cyc=%0d got bits=%0d line=%h exp bits=%0d line=%h",
                                 cyc_n, nbits, rec, DATA_W + 4, {PATTERN, pay});
                    end
                    if (pay == '0) begin
                        checks++;
                        if (hits != 1 || hit_pos != 4) begin
                            errors++;
                            $display("FAIL loopback cyc=%0d got hits=%0d pos=%0d exp hits=1 pos=4",
                                     cyc_n, hits, hit_pos);
                        end else begin
                            loop_ok++;
                        end
                    end
                end
                nbits = 0;
            end else if (busy === 1'b1) begin
                if (nbits == 0) hits = 0;
                rec = {rec[DATA_W+2:0], x_out};
                nbits++;
                win = {win[2:0], x_out};
                if (win == PATTERN) begin
                    hits++;
                    hit_pos = nbits;
                end
            end else begin
                nbits = 0;
                win   = {win[2:0], x_out};
            end
        end
    end

    initial begin
        int base;
        int base_ok;

        // The reset is held with random start and data.
        step(1'b1, 1'($urandom_range(0, 1)), DATA_W'($urandom));
        step(1'b1, 1'($urandom_range(0, 1)), DATA_W'($urandom));
        idle(3);

        // Single frame. start pulses at k+3 and k+13 and the data change at
        // k+2 must all be ignored.
        base = done_cnt;
        step(1'b0, 1'b1, 8'hA5);
        for (int j = 1; j <= 22; j++)
            step(1'b0, (j == 3 || j == 13), (j >= 2) ? 8'h00 : 8'hA5);
        checks++;
        if (done_cnt - base != 1) begin
            errors++;
            $display("FAIL single_done got %0d exp 1", done_cnt - base);
        end

        // Back-to-back frames with start held high.
        base = done_cnt;
        for (int j = 0; j <= 14; j++)
            step(1'b0, 1'b1, (j < 14) ? 8'hFF : 8'h00);
        idle(20);
        checks++;
        if (done_cnt - base != 2 || last_done - prev_done != DATA_W + 6) begin
            errors++;
            $display("FAIL b2b got dones=%0d spacing=%0d exp dones=2 spacing=%0d",
                     done_cnt - base, last_done - prev_done, DATA_W + 6);
        end

        // Reset in the middle of a frame, then a fresh frame.
        base = done_cnt;
        step(1'b0, 1'b1, DATA_W'($urandom));
        for (int j = 1; j <= 6; j++) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, DATA_W'($urandom));
        idle(20);
        checks++;
        if (done_cnt - base != 1) begin
            errors++;
            $display("FAIL abort_done got %0d exp 1", done_cnt - base);
        end

        // Loopback into the detector with an all-zero payload.
        base_ok = loop_ok;
        for (int f = 0; f < 3; f++) begin
            step(1'b0, 1'b1, 8'h00);
            idle(15);
        end
        checks++;
        if (loop_ok - base_ok != 3) begin
            errors++;
            $display("FAIL loopback_frames got %0d exp 3", loop_ok - base_ok);
        end

        // Random traffic with occasional resets.
        for (int j = 0; j < 800; j++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), DATA_W'($urandom));

        idle(20);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0 || frame_q.size() != 0) begin
            errors++;
            $display("FAIL drain got exp_q=%0d frame_q=%0d exp 0 and 0", exp_q.size(), frame_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
